// File: rtl/bit_reservoir_router.sv
// bit_reservoir_router: steers main-data FIFO bits to discard, scalefactor parser or Huffman decoder
// for each granule/channel slot of a frame, after skipping stale reservoir bits.
module bit_reservoir_router #(
    parameter int NUM_GR = 2,
    parameter int NUM_CH = 2,
    parameter int CNT_W  = 16,
    parameter int P23_W  = 12,
    localparam int NS = NUM_GR * NUM_CH,
    localparam int GW = NUM_GR > 1 ? $clog2(NUM_GR) : 1,
    localparam int CW = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [CNT_W-1:0]   fifo_sample_count,
    input  logic               fifo_dout_v,
    input  logic               si_valid_in,
    input  logic [8:0]         main_data_begin,
    input  logic               mono,
    input  logic [NS*P23_W-1:0] part2_3_length,
    input  logic [NS-1:0]      sf_done,
    output logic               res_discard_flag,
    output logic               sf_parser_flag,
    output logic               hf_decoder_flag,
    output logic [GW-1:0]      gr,
    output logic [CW-1:0]      ch,
    output logic               frame_done,
    output logic               frame_skip,
    output logic               busy
);
    typedef enum logic [2:0] {IDLE, DISCARD, HOLD, SF, HUFFMAN} state_t;
    state_t state, state_n;
    logic [GW-1:0] gr_n;
    logic [CW-1:0] ch_n;
    logic [CNT_W-1:0] bit_cnt, bit_n, disc_cnt, disc_n, num_disc, numd_n;
    logic [NS*P23_W-1:0] p23_q, p23_n;
    logic mono_q, mono_n, done_n, skip_n, adv;
    logic [31:0] s;
    logic [CNT_W-1:0] len, need, bit_inc, disc_inc;
    logic [CNT_W:0] bit_p1;
    logic sdone, last_ch, last_gr;
    assign s        = 32'(gr) * NUM_CH + 32'(ch);
    assign len      = CNT_W'(P23_W'(p23_q >> (s * P23_W)));
    assign sdone    = 1'(sf_done >> s);
    assign need     = CNT_W'({main_data_begin, 3'b000});
    assign bit_inc  = bit_cnt + CNT_W'(fifo_dout_v && !(&bit_cnt));
    assign disc_inc = disc_cnt + CNT_W'(fifo_dout_v && !(&disc_cnt));
    assign bit_p1   = {1'b0, bit_cnt} + (CNT_W+1)'(1);
    assign last_ch  = ch == CW'(mono_q ? 0 : NUM_CH - 1);
    assign last_gr  = gr == GW'(NUM_GR - 1);
    assign res_discard_flag = state == DISCARD && disc_cnt < num_disc;
    assign sf_parser_flag   = state == SF && !sdone && bit_cnt < len;
    assign hf_decoder_flag  = state == HUFFMAN && bit_cnt < len;
    assign busy = state != IDLE;
    always_comb begin
        state_n = state;
        gr_n = gr;
        ch_n = ch;
        bit_n = bit_cnt;
        disc_n = disc_cnt;
        numd_n = num_disc;
        p23_n = p23_q;
        mono_n = mono_q;
        done_n = 1'b0;
        skip_n = 1'b0;
        adv = 1'b0;
        if (si_valid_in) begin
            p23_n = part2_3_length;
            mono_n = mono;
            gr_n = '0;
            ch_n = '0;
            bit_n = '0;
            disc_n = '0;
            numd_n = fifo_sample_count > need ? fifo_sample_count - need : '0;
            skip_n = fifo_sample_count < need;
            state_n = fifo_sample_count < need ? IDLE : fifo_sample_count == need ? HOLD : DISCARD;
        end else begin
            case (state)
                DISCARD: begin
                    disc_n = disc_inc;
                    if (disc_cnt == num_disc) state_n = HOLD;
                end
                HOLD: begin
                    if (len == '0) adv = 1'b1;
                    else if (fifo_sample_count >= len) begin
                        state_n = SF;
                        bit_n = '0;
                    end
                end
                SF: begin
                    if (bit_cnt == len) adv = 1'b1;
                    else begin
                        bit_n = bit_inc;
                        if (sdone) state_n = HUFFMAN;
                    end
                end
                HUFFMAN: begin
                    bit_n = bit_inc;
                    adv = bit_cnt == len || (bit_p1 == {1'b0, len} && fifo_dout_v);
                end
                default: ;
            endcase
            // channel-minor slot order; the final slot ends the frame
            if (adv) begin
                bit_n = '0;
                ch_n = last_ch ? '0 : ch + CW'(1);
                gr_n = last_ch && !last_gr ? gr + GW'(1) : gr;
                state_n = last_ch && last_gr ? IDLE : HOLD;
                done_n = last_ch && last_gr;
            end
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            gr <= '0;
            ch <= '0;
            bit_cnt <= '0;
            disc_cnt <= '0;
            num_disc <= '0;
            p23_q <= '0;
            mono_q <= 1'b0;
            frame_done <= 1'b0;
            frame_skip <= 1'b0;
        end else begin
            state <= state_n;
            gr <= gr_n;
            ch <= ch_n;
            bit_cnt <= bit_n;
            disc_cnt <= disc_n;
            num_disc <= numd_n;
            p23_q <= p23_n;
            mono_q <= mono_n;
            frame_done <= done_n;
            frame_skip <= skip_n;
        end
    end
endmodule

// File: doc/bit_reservoir_router.md
BIT_RESERVOIR_ROUTER -- requirements
Module: bit_reservoir_router

Interface
REQ-001 Parameters SHALL be:
- NUM_GR, default 2, granules per frame (1 or 2).
- NUM_CH, default 2, maximum channels (1 or 2).
- CNT_W, default 16, width of the FIFO count and all bit counters.
- P23_W, default 12, part2_3_length field width.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- fifo_sample_count  in  CNT_W  bits currently held in the main-data FIFO.
- fifo_dout_v  in  1  one FIFO bit consumed this cycle.
- si_valid_in  in  1  one-cycle strobe; side info valid.
- main_data_begin  in  9  reservoir back-pointer, in bytes.
- mono  in  1  sampled with si_valid_in; 1 = one channel active.
- part2_3_length  in  NUM_GR*NUM_CH*P23_W  per-slot lengths; slot s = gr*NUM_CH+ch occupies bits [s*P23_W +: P23_W].
- sf_done  in  NUM_GR*NUM_CH  scalefactor parser done, bit s per slot.
- res_discard_flag  out  1  route FIFO bits to discard.
- sf_parser_flag  out  1  route FIFO bits to the scalefactor parser.
- hf_decoder_flag  out  1  route FIFO bits to the Huffman decoder.
- gr  out  max(1,$clog2(NUM_GR))  current granule.
- ch  out  max(1,$clog2(NUM_CH))  current channel.
- frame_done  out  1  one-cycle pulse; last slot finished.
- frame_skip  out  1  one-cycle pulse; reservoir underflow, frame skipped.
- busy  out  1  state != IDLE.

Function
REQ-003 The FSM SHALL have states IDLE, DISCARD, HOLD, SF, HUFFMAN.
REQ-004 On si_valid_in in any state, the block SHALL:
- capture part2_3_length and mono;
- clear gr, ch, bit_cnt and disc_cnt;
- compute need = main_data_begin*8, zero-extended to CNT_W.
REQ-005 With si_valid_in, the next state SHALL be:
- IDLE plus a frame_skip pulse next cycle if fifo_sample_count < need;
- HOLD if fifo_sample_count == need;
- DISCARD otherwise, with num_disc = fifo_sample_count - need.
REQ-006 si_valid_in SHALL take priority over every in-progress transition; the frame in progress is abandoned with no frame_done.
REQ-007 DISCARD behaviour:
- res_discard_flag = (state==DISCARD) && disc_cnt < num_disc.
- disc_cnt increments only on cycles with fifo_dout_v.
- DISCARD -> HOLD on the cycle disc_cnt == num_disc.
REQ-008 HOLD behaviour, with len = captured length of the current slot:
- HOLD -> SF when fifo_sample_count >= len, clearing bit_cnt.
- If len == 0, HOLD SHALL instead advance the slot directly, with no flag asserted.
REQ-009 SF behaviour:
- sf_parser_flag = (state==SF) && !sf_done[s] && bit_cnt < len.
- bit_cnt increments on fifo_dout_v.
- If bit_cnt == len, advance the slot (this has priority over sf_done).
- Else if sf_done[s], go to HUFFMAN; bit_cnt still counts that cycle's fifo_dout_v.
REQ-010 HUFFMAN behaviour:
- hf_decoder_flag = (state==HUFFMAN) && bit_cnt < len.
- bit_cnt increments on fifo_dout_v.
- Advance the slot on the cycle bit_cnt reaches len, i.e. bit_cnt == len, or bit_cnt == len-1 with fifo_dout_v.
REQ-011 Slot advance SHALL follow channel-minor order, with nch = mono ? 1 : NUM_CH:
- ch increments; when ch == nch-1, ch clears and gr increments.
- After gr == NUM_GR-1 and ch == nch-1, go to IDLE and pulse frame_done next cycle.
- Otherwise go to HOLD with bit_cnt cleared.
REQ-012 At most one routing flag SHALL be high in any cycle.
REQ-013 All three flags SHALL be combinational from registered state and counters.
REQ-014 frame_done and frame_skip SHALL be registered, one cycle wide, and never high together.
REQ-015 fifo_dout_v SHALL be ignored in IDLE and HOLD.
REQ-016 Counters SHALL saturate at all-ones and never wrap.

Reset
REQ-017 While rst_n is low, asynchronously and regardless of clk:
- state = IDLE;
- gr = ch = 0;
- bit_cnt = disc_cnt = num_disc = 0;
- all flags, pulses and busy = 0.
REQ-018 Captured lengths and mono SHALL reset to 0.
REQ-019 Deassertion mid-frame SHALL leave the block in IDLE, waiting for the next si_valid_in.

Verification
REQ-020 Discard path:
- Stimulus: count=100, mdb=10 (need=80); fifo_dout_v held high.
- Response: res_discard_flag high for exactly 20 consumed bits, then HOLD.
REQ-021 Full stereo frame:
- Stimulus: lengths {50,60,70,80}; sf_done asserted after 10 bits of each slot; fifo_dout_v every other cycle.
- Response: per slot, sf 10 bits, then hf for the remainder; gr/ch sequence 00,01,10,11; one frame_done.
REQ-022 Underflow:
- Stimulus: count=40, mdb=6 (need=48).
- Response: frame_skip single pulse; busy stays 0; no flags.
REQ-023 Mono and zero-length:
- Stimulus: mono=1, NUM_GR=2, lengths gr0=0, gr1=30.
- Response: gr0 skipped with no flags; gr1 ch0 routes 30 bits; ch never 1; frame_done.
REQ-024 Interrupt and async reset:
- Stimulus: si_valid_in during HUFFMAN of slot 2.
- Response: restart at slot 0, no frame_done.
- Stimulus: rst_n pulsed low between clock edges.
- Response: outputs 0 immediately.
REQ-025 SF length exhaustion:
- Stimulus: len=25 with sf_done never asserted.
- Response: sf_parser_flag for 25 consumed bits, then next slot; HUFFMAN never entered.
